// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, constants, FSM state and classifier result type for the FPU.
// Rev 1.0 -- initial release.
`default_nettype none

package fpu_pkg;

  localparam int EXP_W      = 8;
  localparam int FRAC_W     = 23;
  localparam int BIAS       = 127;
  localparam int MAX_RSHIFT = 25;
  localparam int CNT_W      = 5;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  localparam int FLAG_INVALID = 1;
  localparam int FLAG_INEXACT = 0;

  // Biased exponents where the conversion changes behaviour.
  localparam logic [EXP_W-1:0] EXP_INF = '1;
  localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'(BIAS + 31);
  localparam logic [EXP_W-1:0] EXP_LSH = EXP_W'(BIAS + FRAC_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RSHIFT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic             special;
    logic [31:0]      sat_data;
    logic [1:0]       sat_flags;
    logic             left;
    logic [CNT_W-1:0] cnt;
  } cls_t;

endpackage

`default_nettype wire

// File: rtl/fpu_ftoi_classify.sv
// fpu_ftoi_classify: combinational decode of a packed float into special result or shift plan.
// Rev 1.0 -- initial release.
`default_nettype none

module fpu_ftoi_classify
  import fpu_pkg::*;
(
  input  logic [31:0] data_i,
  output cls_t        cls_o
);

  logic              s;
  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;
  logic [EXP_W-1:0]  rdiff;

  assign s     = data_i[31];
  assign e     = data_i[30:23];
  assign f     = data_i[22:0];
  assign rdiff = EXP_LSH - e;

  always_comb begin
    cls_o = '0;
    if (e == EXP_INF) begin
      cls_o.special                 = 1'b1;
      cls_o.sat_data                = (s && f == '0) ? INT_MIN : INT_MAX;
      cls_o.sat_flags[FLAG_INVALID] = 1'b1;
    end else if (e >= EXP_SAT) begin
      cls_o.special = 1'b1;
      // -2^31 is the one exactly representable value at this magnitude.
      if (s && e == EXP_SAT && f == '0) begin
        cls_o.sat_data = INT_MIN;
      end else begin
        cls_o.sat_data                = s ? INT_MIN : INT_MAX;
        cls_o.sat_flags[FLAG_INVALID] = 1'b1;
      end
    end else if (e == '0) begin
      cls_o.special                 = 1'b1;
      cls_o.sat_flags[FLAG_INEXACT] = |f;
    end else if (e >= EXP_LSH) begin
      cls_o.left = 1'b1;
      cls_o.cnt  = CNT_W'(e - EXP_LSH);
    end else begin
      cls_o.cnt = (rdiff > EXP_W'(MAX_RSHIFT)) ? CNT_MAX : rdiff[CNT_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_ftoi.sv
// fpu_ftoi: multi-cycle float32 -> int32 converter, round-to-nearest-even, valid/ready on both sides.
// Rev 1.0 -- initial release. FPU_FTOI_FLAGS_EN enables the invalid/inexact flag outputs.
`default_nettype none

module fpu_ftoi
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_flags
);

  cls_t             cls;
  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             sign_q, sign_d;
  logic [31:0]      data_q, data_d;
  logic             accept;
  logic             inc;
  logic [31:0]      mag;

  fpu_ftoi_classify u_classify (
    .data_i (in_data),
    .cls_o  (cls)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign accept    = in_valid && in_ready;

  // Largest left-shifted magnitude is 0x7FFFFF80, so the increment never overflows.
  assign inc = guard_q & (sticky_q | acc_q[0]);
  assign mag = acc_q + {31'b0, inc};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sign_d   = sign_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = in_data[31];
          if (cls.special) begin
            data_d  = cls.sat_data;
            state_d = DONE;
          end else begin
            acc_d    = {8'b0, 1'b1, in_data[FRAC_W-1:0]};
            guard_d  = 1'b0;
            sticky_d = 1'b0;
            cnt_d    = cls.cnt;
            left_d   = cls.left;
            state_d  = (cls.cnt != '0) ? SHIFT : ROUND;
          end
        end
      end
      SHIFT: begin
        if (left_q) begin
          acc_d = acc_q << 1;
        end else begin
          sticky_d = sticky_q | guard_q;
          guard_d  = acc_q[0];
          acc_d    = acc_q >> 1;
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d  = sign_q ? -mag : mag;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      sign_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sign_q   <= sign_d;
      data_q   <= data_d;
    end
  end

`ifdef FPU_FTOI_FLAGS_EN
  logic [1:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (accept && cls.special) begin
      flags_d = cls.sat_flags;
    end else if (state_q == ROUND) begin
      flags_d               = '0;
      flags_d[FLAG_INEXACT] = guard_q | sticky_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign out_flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^cls.sat_flags;
  assign out_flags    = 2'b00;
`endif

endmodule

`default_nettype wire

// File: doc/fpu_ftoi.md
# fpu_ftoi

Multi-cycle converter from IEEE-754 single-precision to signed 32-bit integer, round-to-nearest-even. It is the decode-side counterpart of the FPU adder's pack/normalize path: it takes a packed float apart, de-normalizes the significand by iterative shifting and rounds with guard/sticky. It sits beside the adder in the FPU and uses valid/ready handshakes on both sides.

## Interface
- No parameters; all widths come from `fpu_pkg`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_data` holds an operand.
- `in_ready` out 1: block is idle and will accept an operand.
- `in_data` in 32: IEEE-754 single {sign, exp[7:0], frac[22:0]}.
- `out_valid` out 1: result is available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 32: two's-complement integer result.
- `out_flags` out 2: bit 1 = invalid, bit 0 = inexact.

## Operation
- **Accept:** an operand is taken when `in_valid & in_ready`. `in_ready` = (state == IDLE).
- **Unpack** on accept:
  - s = sign, e = exp, E = e − 127, m = {1, frac} (24 bit).
- **Special cases** go straight to DONE, in priority order:
  - e == 255, NaN or ±inf: +inf and NaN → 0x7FFFFFFF, −inf → 0x80000000; invalid = 1.
  - E ≥ 31: s = 1 with e == 158 and frac == 0 → 0x80000000 with no flags. Otherwise saturate toward sign (0x7FFFFFFF / 0x80000000) with invalid = 1.
  - e == 0 (zero or subnormal) → 0. inexact = (frac != 0). −0 → 0.
- **Normal path:**
  - acc[31:0] = {8'b0, m}, guard = 0, sticky = 0.
  - 23 ≤ E ≤ 30: left shift, count = E − 23 (0..7).
  - E < 23: right shift, count = min(23 − E, 25).
  - State SHIFT, one bit per cycle while count != 0.
    - Left: acc <<= 1.
    - Right: sticky |= guard; guard = acc[0]; acc >>= 1.
  - State ROUND, one cycle:
    - inc = guard & (sticky | acc[0]).
    - mag = acc + inc. Cannot exceed 2^31 − 1.
    - out_data = s ? −mag : mag. inexact = guard | sticky.
- **FSM:**
  - IDLE → (accept, special) DONE.
  - IDLE → (accept, normal) SHIFT if count != 0, else ROUND.
  - SHIFT → ROUND when count reaches 0.
  - ROUND → DONE.
  - DONE → IDLE on `out_ready`.
- `out_valid` = (state == DONE). `out_data` and `out_flags` stay stable while `out_valid & !out_ready`.
- No new operand is accepted in the same cycle that DONE hands off; `in_ready` rises the cycle after.

## Timing
- **Reset values:** state = IDLE, `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_flags` = 0, acc/guard/sticky/count = 0.
- **Latency**, with accept at edge k:
  - Special case: `out_valid` high after edge k+1.
  - Normal case: `out_valid` high after edge k+n+2, where n = shift count. Worst case is 27 cycles.
- **Throughput:** one operation in flight. Issue interval = latency + 1 with `out_ready` held high.
- **Reset mid-operation:** an in-flight result is discarded with no output. The block is IDLE the cycle after reset.
- `in_data` is captured at accept only. Later changes on `in_data` have no effect.

## Configuration
- `FPU_FTOI_FLAGS_EN`:
  - Defined: `out_flags` is computed and registered as described.
  - Undefined: `out_flags` is tied to 2'b00, and the flag registers and flag logic are removed.
  - Data results and timing are identical either way.

## Structure
- `fpu_pkg` holds:
  - Constants: EXP_W = 8, FRAC_W = 23, BIAS = 127, INT_MAX = 32'h7FFFFFFF, INT_MIN = 32'h80000000, MAX_RSHIFT = 25.
  - Flag bit indices: FLAG_INVALID = 1, FLAG_INEXACT = 0.
  - The FSM state enum {IDLE, SHIFT, ROUND, DONE}.
- Sub-module `fpu_ftoi_classify`, combinational, decodes `in_data` into:
  - special/zero/overflow class;
  - the saturated result and its flags;
  - shift direction and count.
- `fpu_ftoi` holds the FSM, datapath registers and handshake.

## Test plan
- 0x3FC00000 (1.5) → 2, flags 01. `out_valid` asserts 25 cycles after accept.
- 0x40200000 (2.5) → 2, flags 01 (tie to even).
- 0xC0E00000 (−7.0) → 0xFFFFFFF9, flags 00. 0x3ECCCCCD (0.4) → 0, flags 01, shift count capped at 25.
- 0x4F000000 (2^31) → 0x7FFFFFFF, flags 10. 0xCF000000 → 0x80000000, flags 00. 0x7FC00000 (NaN) → 0x7FFFFFFF, flags 10, 1-cycle latency.
- 0x4EFFFFFF → 0x7FFFFF80 via 7 left shifts. Hold `out_ready` low for 5 cycles: `out_data` stays stable and `in_ready` stays 0 throughout.
- Accept 0x3F800000, assert `rst` on the 5th SHIFT cycle: `out_valid` never rises and `in_ready` = 1 the next cycle. A following operand 0x41200000 → 10.
